regfile_wb_arbiter: RTL and testbench

// Shares the single register-file write port between two writeback requesters
// (A = ALU result, B = memory load) using round-robin arbitration. It drives the

---
 rtl/regfile_wb_arbiter.sv | 78 +++++++
 tb/tb_regfile_wb_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (A) and
// load (B) writeback paths, with a registered write stage and a pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  input  logic [ADDR_W-1:0]    a_reg,
  input  logic [DATA_W-1:0]    a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [ADDR_W-1:0]    b_reg,
  input  logic [DATA_W-1:0]    b_data,
  output logic                 b_ready,
  input  logic                 wr_hold,
  input  logic                 claim_valid,
  input  logic [ADDR_W-1:0]    claim_reg,
  output logic [DATA_W-1:0]    wr_data,
  output logic [ADDR_W-1:0]    wr_reg,
  output logic                 reg_write,
  output logic [2**ADDR_W-1:0] busy
);

  localparam int NREG = 2**ADDR_W;

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_e;

  prio_e               prio;
  logic                accept;
  logic [ADDR_W-1:0]   sel_reg;
  logic [DATA_W-1:0]   sel_data;
  logic [NREG-1:0]     busy_next;

  // Ready looks only at the other side's valid, never its ready, so no comb loop.
  assign a_ready  = a_valid && !wr_hold && (!b_valid || prio == PRIO_A);
  assign b_ready  = b_valid && !wr_hold && (!a_valid || prio == PRIO_B);
  assign accept   = a_ready || b_ready;
  assign sel_reg  = a_ready ? a_reg  : b_reg;
  assign sel_data = a_ready ? a_data : b_data;

  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    busy_next = busy;
    if (reg_write)
      busy_next[wr_reg] = 1'b0;
    // Set after clear: a claim landing on the commit edge keeps the register busy.
    if (claim_valid)
      busy_next[claim_reg] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio      <= PRIO_A;
      reg_write <= 1'b0;
      wr_reg    <= '0;
      wr_data   <= '0;
      busy      <= '0;
    end else begin
      busy <= busy_next;
      if (a_ready)
        prio <= PRIO_B;
      else if (b_ready)
        prio <= PRIO_A;
      if (accept) begin
        wr_reg    <= sel_reg;
        wr_data   <= sel_data;
        reg_write <= (sel_reg != '0);
      end else begin
        reg_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a reference model predicts grants and busy bits,
// and accepted writes are queued and matched against the registered write port.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, wr_hold, claim_valid;
  logic [3:0]  a_reg, b_reg, claim_reg;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, reg_write;
  logic [31:0] wr_data;
  logic [3:0]  wr_reg;
  logic [15:0] busy;

  typedef struct {
    logic        we;
    logic [3:0]  rg;
    logic [31:0] data;
  } wb_t;

  wb_t         exp_q[$];
  logic        m_prio_b;
  logic [15:0] m_busy;
  logic        m_we;
  logic [3:0]  m_wreg;
  logic [31:0] m_wdata;
  int          n_tests = 0;
  int          n_fail  = 0;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .wr_hold(wr_hold), .claim_valid(claim_valid), .claim_reg(claim_reg),
    .wr_data(wr_data), .wr_reg(wr_reg), .reg_write(reg_write), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prio_b = 1'b0;
    m_busy   = '0;
    m_we     = 1'b0;
    m_wreg   = '0;
    m_wdata  = '0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; wr_hold = 0; claim_valid = 0;
    a_reg = 0; b_reg = 0; claim_reg = 0; a_data = 0; b_data = 0;
  endtask

  // Called at posedge+1 after inputs are driven; checks ready, then the outputs of the next edge.
  task automatic cycle(input string tag);
    logic        ea, eb;
    logic [15:0] nb;
    wb_t         item;
    #1;
    ea = a_valid && !wr_hold && (!b_valid || !m_prio_b);
    eb = b_valid && !wr_hold && (!a_valid ||  m_prio_b);
    check({tag, ".a_ready"}, {31'b0, a_ready}, {31'b0, ea});
    check({tag, ".b_ready"}, {31'b0, b_ready}, {31'b0, eb});
    if (ea)      exp_q.push_back('{we: (a_reg != 0), rg: a_reg, data: a_data});
    else if (eb) exp_q.push_back('{we: (b_reg != 0), rg: b_reg, data: b_data});
    nb = m_busy;
    if (m_we) nb[m_wreg] = 1'b0;
    if (claim_valid && claim_reg != 0) nb[claim_reg] = 1'b1;
    if (ea)      m_prio_b = 1'b1;
    else if (eb) m_prio_b = 1'b0;
    @(posedge clk); #1;
    m_busy = nb;
    if (exp_q.size() > 0) begin
      item    = exp_q.pop_front();
      m_we    = item.we;
      m_wreg  = item.rg;
      m_wdata = item.data;
    end else begin
      m_we = 1'b0;
    end
    check({tag, ".reg_write"}, {31'b0, reg_write}, {31'b0, m_we});
    check({tag, ".wr_reg"},    {28'b0, wr_reg},    {28'b0, m_wreg});
    check({tag, ".wr_data"},   wr_data,            m_wdata);
    check({tag, ".busy"},      {16'b0, busy},      {16'b0, m_busy});
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    check("reset.reg_write", {31'b0, reg_write}, 32'd0);
    check("reset.wr_reg",    {28'b0, wr_reg},    32'd0);
    check("reset.wr_data",   wr_data,            32'd0);
    check("reset.busy",      {16'b0, busy},      32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Single A write, then idle: reg_write high for exactly one cycle.
    a_valid = 1; a_reg = 5; a_data = 32'hDEADBEEF;
    cycle("single");
    a_valid = 0;
    cycle("single_idle");

    // B writes R0 while claiming R0: accepted, no write enable, busy[0] stays 0.
    b_valid = 1; b_reg = 0; b_data = 32'h0BAD_0000;
    claim_valid = 1; claim_reg = 0;
    cycle("r0");
    b_valid = 0; claim_valid = 0;
    cycle("r0_idle");

    // Contention: grants must alternate A,B,A,B committing r1..r4 in order.
    a_valid = 1; a_reg = 1; a_data = 32'h1111_0001;
    b_valid = 1; b_reg = 2; b_data = 32'h2222_0002;
    cycle("cont1");
    a_reg = 3; a_data = 32'h3333_0003;
    cycle("cont2");
    b_reg = 4; b_data = 32'h4444_0004;
    cycle("cont3");
    a_valid = 0;
    cycle("cont4");
    b_valid = 0;
    cycle("cont_idle");

    // Hold blocks both requesters for three cycles; A wins on release.
    a_valid = 1; a_reg = 10; a_data = 32'hAAAA_000A;
    b_valid = 1; b_reg = 11; b_data = 32'hBBBB_000B;
    wr_hold = 1;
    for (int i = 0; i < 3; i++) cycle("hold");
    wr_hold = 0;
    cycle("hold_rel_a");
    a_valid = 0;
    cycle("hold_rel_b");
    b_valid = 0;
    cycle("hold_idle");

    // Scoreboard: claim r7, write r7 clears it, claim on the commit edge keeps it set.
    claim_valid = 1; claim_reg = 7;
    cycle("sb_claim");
    claim_valid = 0;
    a_valid = 1; a_reg = 7; a_data = 32'h7777_0007;
    cycle("sb_write");
    a_valid = 0;
    cycle("sb_commit");
    check("sb_cleared", {31'b0, busy[7]}, 32'd0);
    claim_valid = 1; claim_reg = 7;
    cycle("sb_claim2");
    claim_valid = 0;
    b_valid = 1; b_reg = 7; b_data = 32'h7777_0017;
    cycle("sb_write2");
    b_valid = 0; claim_valid = 1; claim_reg = 7;
    cycle("sb_setwins");
    check("sb_kept", {31'b0, busy[7]}, 32'd1);
    claim_valid = 0;
    cycle("sb_idle");

    // Reset while a write is on the port and busy bits are set.
    claim_valid = 1; claim_reg = 9;
    a_valid = 1; a_reg = 9; a_data = 32'h9999_0009;
    cycle("mid_write");
    idle_inputs();
    #2 rst = 1'b0;
    #1;
    check("mid_rst.reg_write", {31'b0, reg_write}, 32'd0);
    check("mid_rst.wr_reg",    {28'b0, wr_reg},    32'd0);
    check("mid_rst.busy",      {16'b0, busy},      32'd0);
    model_reset();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Priority is back to A after reset even though A won last.
    a_valid = 1; a_reg = 12; a_data = 32'hC0DE_000C;
    b_valid = 1; b_reg = 13; b_data = 32'hC0DE_000D;
    cycle("post_rst_a");
    a_valid = 0;
    cycle("post_rst_b");
    b_valid = 0;
    cycle("post_rst_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
